// File: rtl/cpu_mem_arbiter.sv
// Merges the core's fetch and data ports onto one single-port, variable-latency memory bus.
// A one-entry fetch buffer supplies zero-stall fetches while the PC is held.
module cpu_mem_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    input  logic [31:0] d_addr,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        mem_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        bus_err
);

    localparam int unsigned     CntW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'(ACK_TIMEOUT - 1);
    localparam bit              TmoEn   = (ACK_TIMEOUT != 0);

    typedef enum logic [1:0] {StIdle, StWrWait, StRdWait, StIfWait} state_e;

    state_e          state_q;
    logic [31:0]     addr_q;
    logic [CntW-1:0] tmo_cnt_q;
    logic            fetch_valid_q;
    logic [31:0]     fetch_addr_q;
    logic            rd_done_q;
    logic            wr_done_q;
    logic            m_req_q;
    logic            m_we_q;
    logic [31:0]     m_wdata_q;
    logic [3:0]      m_be_q;
    logic [31:0]     i_data_q;
    logic [31:0]     d_rdata_q;
    logic            bus_err_q;

    logic fetch_hit;
    logic wr_pend;
    logic rd_pend;
    logic timeout;
    logic finish;

    assign fetch_hit = fetch_valid_q && (fetch_addr_q == i_addr);
    assign wr_pend   = d_wen && !wr_done_q;
    assign rd_pend   = d_ren && !rd_done_q;
    assign mem_ready = fetch_hit && !wr_pend && !rd_pend;

    assign timeout = TmoEn && (tmo_cnt_q == TmoLast);
    // Only meaningful while a request is outstanding; stray acks in idle are ignored.
    assign finish  = (state_q != StIdle) && (m_ack || timeout);

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = {addr_q[31:2], 2'b00};
    assign m_wdata = m_wdata_q;
    assign m_be    = m_be_q;
    assign i_data  = i_data_q;
    assign d_rdata = d_rdata_q;
    assign bus_err = bus_err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            tmo_cnt_q     <= '0;
            fetch_valid_q <= 1'b0;
            fetch_addr_q  <= '0;
            rd_done_q     <= 1'b0;
            wr_done_q     <= 1'b0;
            m_req_q       <= 1'b0;
            m_we_q        <= 1'b0;
            m_wdata_q     <= '0;
            m_be_q        <= '0;
            i_data_q      <= '0;
            d_rdata_q     <= '0;
            bus_err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tmo_cnt_q <= '0;
                    if (wr_pend) begin
                        state_q   <= StWrWait;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b1;
                        addr_q    <= d_addr;
                        m_wdata_q <= d_wdata;
                        m_be_q    <= d_be;
                    end else if (rd_pend) begin
                        state_q <= StRdWait;
                        m_req_q <= 1'b1;
                        m_we_q  <= 1'b0;
                        addr_q  <= d_addr;
                        m_be_q  <= 4'hF;
                    end else if (!fetch_hit) begin
                        state_q <= StIfWait;
                        m_req_q <= 1'b1;
                        m_we_q  <= 1'b0;
                        addr_q  <= i_addr;
                        m_be_q  <= 4'hF;
                    end
                end
                default: begin
                    if (finish) begin
                        state_q   <= StIdle;
                        m_req_q   <= 1'b0;
                        m_we_q    <= 1'b0;
                        tmo_cnt_q <= '0;
                        if (!m_ack) begin
                            bus_err_q <= 1'b1;
                        end
                        case (state_q)
                            StWrWait: begin
                                wr_done_q <= 1'b1;
                                // A real write over the buffered instruction makes it stale.
                                if (m_ack && (addr_q[31:2] == fetch_addr_q[31:2])) begin
                                    fetch_valid_q <= 1'b0;
                                end
                            end
                            StRdWait: begin
                                d_rdata_q <= m_ack ? m_rdata : 32'h0;
                                rd_done_q <= 1'b1;
                            end
                            default: begin
                                i_data_q      <= m_ack ? m_rdata : NOP_INSTR;
                                fetch_addr_q  <= addr_q;
                                fetch_valid_q <= 1'b1;
                            end
                        endcase
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
            endcase
            // Pipeline advanced: data-side completions are consumed.
            if (mem_ready) begin
                rd_done_q <= 1'b0;
                wr_done_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: a transaction-level model compared every cycle,
// a behavioural memory backend, and directed scenarios with literal expectations.
module tb_cpu_mem_arbiter;

    localparam int          TMO = 8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock;
    logic        reset;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [31:0] d_addr;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        mem_ready;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        bus_err;

    cpu_mem_arbiter #(
        .ACK_TIMEOUT(TMO),
        .NOP_INSTR  (NOP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .d_addr   (d_addr),
        .d_ren    (d_ren),
        .d_wen    (d_wen),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_rdata  (d_rdata),
        .mem_ready(mem_ready),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata),
        .bus_err  (bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors;
    int miscompares;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Backend memory, 256 words.
    logic [31:0] mem [0:255];
    int          ack_delay;
    bit          ack_en;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    // Backend: acks in the ack_delay-th cycle of m_req, commits writes on the accepting edge.
    initial begin : responder
        logic        pr, pa, pwe;
        logic [31:0] pad, pwd;
        logic [3:0]  pbe;
        int          cnt;
        m_ack   = 1'b0;
        m_rdata = '0;
        cnt     = 0;
        forever begin
            @(negedge clock);
            pr  = m_req;
            pa  = m_ack;
            pwe = m_we;
            pad = m_addr;
            pwd = m_wdata;
            pbe = m_be;
            @(posedge clock);
            #1;
            if (!reset) begin
                cnt   = 0;
                m_ack = 1'b0;
            end else begin
                if (pr && pa && pwe) begin
                    for (int b = 0; b < 4; b++) begin
                        if (pbe[b]) mem[pad[9:2]][8*b +: 8] = pwd[8*b +: 8];
                    end
                end
                if (m_req) begin
                    cnt++;
                    m_ack   = ack_en && (cnt >= ack_delay);
                    m_rdata = m_ack ? mem_rd(m_addr) : 32'hDEADBEEF;
                end else begin
                    cnt   = 0;
                    m_ack = 1'b0;
                end
            end
        end
    end

    // Bus transaction log (captured at each rising m_req).
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t log_q[$];
    bit   prev_req;

    initial begin : monitor
        txn_t t;
        prev_req = 1'b0;
        forever begin
            @(negedge clock);
            if (m_req && !prev_req) begin
                t.we    = m_we;
                t.addr  = m_addr;
                t.wdata = m_wdata;
                t.be    = m_be;
                log_q.push_back(t);
            end
            prev_req = m_req;
        end
    end

    // Transaction-level model: one outstanding bus job, a one-word instruction buffer,
    // and the "already done" flags for the current data request.
    initial begin : model
        bit          fv, rdn, wrn, err, busy, hit, wp, rp, rdy;
        logic [31:0] fa, idat, rdat, taddr, twd;
        logic [3:0]  tbe;
        int          kind;  // 0 fetch, 1 read, 2 write
        int          cyc;
        forever begin
            @(negedge clock);
            if (!reset) begin
                fv = 0; rdn = 0; wrn = 0; err = 0; busy = 0;
                fa = '0; idat = '0; rdat = '0;
                check("rst_m_req", {31'b0, m_req}, 32'd0);
                check("rst_m_we", {31'b0, m_we}, 32'd0);
                check("rst_m_addr", m_addr, 32'd0);
                check("rst_m_wdata", m_wdata, 32'd0);
                check("rst_m_be", {28'b0, m_be}, 32'd0);
                check("rst_i_data", i_data, 32'd0);
                check("rst_d_rdata", d_rdata, 32'd0);
                check("rst_bus_err", {31'b0, bus_err}, 32'd0);
                check("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
            end else begin
                hit = fv && (fa == i_addr);
                wp  = d_wen && !wrn;
                rp  = d_ren && !rdn;
                rdy = hit && !wp && !rp;
                check("mdl_mem_ready", {31'b0, mem_ready}, {31'b0, rdy});
                check("mdl_m_req", {31'b0, m_req}, {31'b0, busy});
                check("mdl_i_data", i_data, idat);
                check("mdl_d_rdata", d_rdata, rdat);
                check("mdl_bus_err", {31'b0, bus_err}, {31'b0, err});
                if (busy) begin
                    check("mdl_m_we", {31'b0, m_we}, (kind == 2) ? 32'd1 : 32'd0);
                    check("mdl_m_addr", m_addr, {taddr[31:2], 2'b00});
                    check("mdl_m_be", {28'b0, m_be}, {28'b0, tbe});
                    if (kind == 2) check("mdl_m_wdata", m_wdata, twd);
                end
                if (busy) begin
                    if (m_ack || cyc == TMO) begin
                        if (kind == 2) begin
                            wrn = 1;
                            if (m_ack && taddr[31:2] == fa[31:2]) fv = 0;
                        end else if (kind == 1) begin
                            rdat = m_ack ? mem_rd(taddr) : 32'h0;
                            rdn  = 1;
                        end else begin
                            idat = m_ack ? mem_rd(taddr) : NOP;
                            fa   = taddr;
                            fv   = 1;
                        end
                        if (!m_ack) err = 1;
                        busy = 0;
                    end else begin
                        cyc++;
                    end
                end else if (wp) begin
                    busy = 1; kind = 2; cyc = 1; taddr = d_addr; twd = d_wdata; tbe = d_be;
                end else if (rp) begin
                    busy = 1; kind = 1; cyc = 1; taddr = d_addr; tbe = 4'hF;
                end else if (!hit) begin
                    busy = 1; kind = 0; cyc = 1; taddr = i_addr; tbe = 4'hF;
                end
                if (rdy) begin
                    rdn = 0;
                    wrn = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic wait_ready(input string nm, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!mem_ready && n < budget);
        check(nm, {31'b0, mem_ready}, 32'd1);
    endtask

    task automatic wait_req(input string nm, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!m_req && n < budget);
        check(nm, {31'b0, m_req}, 32'd1);
    endtask

    task automatic edge_drive();
        @(posedge clock);
        #2;
    endtask

    initial begin : main
        int          rises, low, hi, n;
        bit          got;
        logic [31:0] cap_addr;
        logic [3:0]  cap_be;
        logic        cap_we;

        vectors     = 0;
        miscompares = 0;
        reset   = 1'b0;
        i_addr  = '0;
        d_addr  = '0;
        d_ren   = 1'b0;
        d_wen   = 1'b0;
        d_wdata = '0;
        d_be    = '0;
        ack_delay = 1;
        ack_en    = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[0]    = 32'h00500093;
        mem[1]    = 32'h00a00113;
        mem[2]    = 32'h00000293;
        mem[8'h41] = 32'hAABBCCDD;

        // 1: reset release, first fetch of address 0
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(negedge clock);
        check("t1_req_before_edge", {31'b0, m_req}, 32'd0);
        @(negedge clock);
        check("t1_req_issued", {31'b0, m_req}, 32'd1);
        check("t1_addr", m_addr, 32'h0);
        check("t1_we", {31'b0, m_we}, 32'd0);
        @(negedge clock);
        check("t1_ready", {31'b0, mem_ready}, 32'd1);
        check("t1_i_data", i_data, 32'h00500093);

        // 2: held PC hits; stepping the PC causes exactly one fetch
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("t2_hold_ready", {31'b0, mem_ready}, 32'd1);
            check("t2_hold_noreq", {31'b0, m_req}, 32'd0);
        end
        edge_drive();
        i_addr   = 32'h4;
        rises    = 0;
        cap_addr = '0;
        got      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (m_req && !got) begin
                rises++;
                cap_addr = m_addr;
            end
            got = m_req;
        end
        check("t2_one_fetch", rises, 32'd1);
        check("t2_fetch_addr", cap_addr, 32'h4);
        check("t2_i_data", i_data, 32'h00a00113);

        // 3: data read, 3-cycle ack
        ack_delay = 3;
        edge_drive();
        d_addr = 32'h106;
        d_ren  = 1'b1;
        low = 0; n = 0; got = 1'b0;
        cap_addr = '0; cap_be = '0; cap_we = 1'b1;
        while (n < 30) begin
            @(negedge clock);
            n++;
            if (m_req && !got) begin
                got = 1'b1; cap_addr = m_addr; cap_be = m_be; cap_we = m_we;
            end
            if (mem_ready) break;
            low++;
        end
        check("t3_ready", {31'b0, mem_ready}, 32'd1);
        check("t3_stall_cycles", low, 32'd4);
        check("t3_m_addr", cap_addr, 32'h104);
        check("t3_m_be", {28'b0, cap_be}, 32'hF);
        check("t3_m_we", {31'b0, cap_we}, 32'd0);
        check("t3_d_rdata", d_rdata, 32'hAABBCCDD);
        // ren still high after the advancing edge: it is a new read, so the core stalls again
        @(negedge clock);
        check("t3_done_cleared", {31'b0, mem_ready}, 32'd0);
        wait_ready("t3_second_read", 20);
        check("t3_d_rdata_again", d_rdata, 32'hAABBCCDD);
        edge_drive();
        d_ren = 1'b0;

        // 4: write+read to the buffered fetch address
        ack_delay = 2;
        edge_drive();
        log_q.delete();
        d_addr  = 32'h4;
        d_wdata = 32'h0000BEEF;
        d_be    = 4'b0011;
        d_wen   = 1'b1;
        d_ren   = 1'b1;
        wait_ready("t4_ready", 40);
        check("t4_txn_count", log_q.size(), 32'd3);
        if (log_q.size() >= 3) begin
            check("t4_w_we", {31'b0, log_q[0].we}, 32'd1);
            check("t4_w_be", {28'b0, log_q[0].be}, 32'h3);
            check("t4_w_addr", log_q[0].addr, 32'h4);
            check("t4_w_data", log_q[0].wdata, 32'h0000BEEF);
            check("t4_r_we", {31'b0, log_q[1].we}, 32'd0);
            check("t4_r_be", {28'b0, log_q[1].be}, 32'hF);
            check("t4_f_addr", log_q[2].addr, 32'h4);
            check("t4_f_we", {31'b0, log_q[2].we}, 32'd0);
        end
        check("t4_mem", mem[1], 32'h00a0BEEF);
        check("t4_d_rdata", d_rdata, 32'h00a0BEEF);
        check("t4_i_data", i_data, 32'h00a0BEEF);
        edge_drive();
        d_wen = 1'b0;
        d_ren = 1'b0;

        // 5: fetch with no ack times out
        edge_drive();
        ack_en = 1'b0;
        i_addr = 32'h8;
        wait_req("t5_req", 10);
        hi = 1;
        n  = 0;
        while (n < 30) begin
            @(negedge clock);
            n++;
            if (!m_req) break;
            hi++;
        end
        check("t5_req_cycles", hi, TMO);
        check("t5_req_dropped", {31'b0, m_req}, 32'd0);
        check("t5_bus_err", {31'b0, bus_err}, 32'd1);
        check("t5_i_data_nop", i_data, 32'h00000013);
        check("t5_ready", {31'b0, mem_ready}, 32'd1);
        ack_en = 1'b1;

        // 6: reset during a read
        ack_delay = 5;
        edge_drive();
        d_addr = 32'h20;
        d_ren  = 1'b1;
        wait_req("t6_req", 10);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("t6_req_drop", {31'b0, m_req}, 32'd0);
        check("t6_m_wdata", m_wdata, 32'd0);
        check("t6_bus_err", {31'b0, bus_err}, 32'd0);
        check("t6_i_data", i_data, 32'd0);
        check("t6_d_rdata", d_rdata, 32'd0);
        d_ren = 1'b0;
        @(posedge clock);
        #3 reset = 1'b1;
        @(negedge clock);
        check("t6_idle_after_rel", {31'b0, m_req}, 32'd0);
        @(negedge clock);
        check("t6_refetch_req", {31'b0, m_req}, 32'd1);
        check("t6_refetch_addr", m_addr, 32'h8);
        wait_ready("t6_ready", 20);
        check("t6_i_data_fill", i_data, 32'h00000293);
        check("t6_bus_err_clear", {31'b0, bus_err}, 32'd0);

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
